// File: rtl/cache_pkg.sv
// Geometry and address-field helpers for the direct-mapped lookup cache.
package cache_pkg;

    localparam int LINES    = 8;
    localparam int BLOCK_W  = 32;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BYTE_W   = 8;
    localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

    typedef logic [TAG_W-1:0]         tag_t;
    typedef logic [INDEX_W-1:0]       index_t;
    typedef logic [OFFSET_W-1:0]      offset_t;
    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic [BLOCK_W-1:0]       block_t;
    typedef logic [BYTE_W-1:0]        byte_t;
    typedef logic [TAG_W+INDEX_W-1:0] baddr_t;

    typedef struct packed {
        logic   valid;
        logic   dirty;
        tag_t   tag;
        block_t data;
    } line_t;

    function automatic tag_t addr_tag(addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(addr_t a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(addr_t a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_lookup_if.sv
// CPU / miss-controller side bundle of the lookup cache.
interface cache_lookup_if;
    import cache_pkg::*;

    addr_t  address;
    logic   read;
    logic   write;
    byte_t  writedata;
    logic   fill;
    block_t filldata;
    byte_t  readdata;
    logic   hit;
    logic   miss;
    logic   dirty;
    baddr_t refill_address;
    baddr_t wb_address;
    block_t evict_block;

    modport master (
        output address, read, write, writedata, fill, filldata,
        input  readdata, hit, miss, dirty,
        input  refill_address, wb_address, evict_block
    );

    modport slave (
        input  address, read, write, writedata, fill, filldata,
        output readdata, hit, miss, dirty,
        output refill_address, wb_address, evict_block
    );

endinterface

// File: rtl/cache_byte_select.sv
// Picks one byte lane out of a 32-bit block.
module cache_byte_select (
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    input  logic [7:0] b3,
    input  logic [1:0] sel,
    output logic [7:0] y
);

    always_comb begin
        y = b0;
        unique case (sel)
            2'd0: y = b0;
            2'd1: y = b1;
            2'd2: y = b2;
            2'd3: y = b3;
        endcase
    end

endmodule

// File: rtl/cache_lookup.sv
// Direct-mapped 8-line cache lookup with write-hit merge and refill.
module cache_lookup
    import cache_pkg::*;
(
    input  logic CLOCK,
    input  logic RESET_CACHE,
    cache_lookup_if.slave bus
);

    line_t   lines [LINES];
    tag_t    tag;
    index_t  idx;
    offset_t off;
    line_t   cur;
    logic    access;
    logic    tag_match;
    logic    write_hit;
    block_t  merged;

    assign tag = addr_tag(bus.address);
    assign idx = addr_index(bus.address);
    assign off = addr_offset(bus.address);
    assign cur = lines[idx];

    assign access    = bus.read ^ bus.write;
    assign tag_match = cur.valid && (cur.tag == tag);
    assign write_hit = bus.write && !bus.read && tag_match;

    assign bus.hit            = access && tag_match;
    assign bus.miss           = access && !tag_match;
    assign bus.dirty          = cur.valid && cur.dirty;
    assign bus.refill_address = {tag, idx};
    assign bus.wb_address     = {cur.tag, idx};
    assign bus.evict_block    = cur.data;

    cache_byte_select u_sel (
        .b0  (cur.data[7:0]),
        .b1  (cur.data[15:8]),
        .b2  (cur.data[23:16]),
        .b3  (cur.data[31:24]),
        .sel (off),
        .y   (bus.readdata)
    );

    always_comb begin
        merged = cur.data;
        unique case (off)
            2'd0: merged[7:0]   = bus.writedata;
            2'd1: merged[15:8]  = bus.writedata;
            2'd2: merged[23:16] = bus.writedata;
            2'd3: merged[31:24] = bus.writedata;
        endcase
    end

    // Refill overrides a coincident write hit; the written byte is dropped.
    always_ff @(posedge CLOCK or negedge RESET_CACHE) begin
        if (!RESET_CACHE) begin
            for (int i = 0; i < LINES; i++) begin
                lines[i] <= '0;
            end
        end else if (bus.fill) begin
            lines[idx].valid <= 1'b1;
            lines[idx].dirty <= 1'b0;
            lines[idx].tag   <= tag;
            lines[idx].data  <= bus.filldata;
        end else if (write_hit) begin
            lines[idx].dirty <= 1'b1;
            lines[idx].data  <= merged;
        end
    end

endmodule

// File: tb/tb_cache_lookup.sv
// Directed bench for cache_lookup with hand-computed expectations.
module tb_cache_lookup;

    logic CLOCK;
    logic RESET_CACHE;
    int   total;
    int   bad;

    cache_lookup_if bus ();

    cache_lookup dut (
        .CLOCK       (CLOCK),
        .RESET_CACHE (RESET_CACHE),
        .bus         (bus)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.fill  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        idle();
        bus.address = a;
        bus.read    = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET_CACHE   = 1'b0;
        bus.address   = 8'h25;
        bus.read      = 1'b1;
        bus.write     = 1'b0;
        bus.writedata = 8'h00;
        bus.fill      = 1'b0;
        bus.filldata  = 32'h0;
        #2;
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_miss", 32'(bus.miss), 32'd1);
        check("rst_dirty", 32'(bus.dirty), 32'd0);
        check("rst_rdata", 32'(bus.readdata), 32'h0);
        check("rst_evict", bus.evict_block, 32'h0);
        edge1();
        RESET_CACHE = 1'b1;
        edge1();

        rd(8'h25);
        check("cold_hit", 32'(bus.hit), 32'd0);
        check("cold_miss", 32'(bus.miss), 32'd1);
        check("cold_dirty", 32'(bus.dirty), 32'd0);
        check("cold_refill", 32'(bus.refill_address), 32'h09);

        idle();
        bus.address  = 8'h25;
        bus.fill     = 1'b1;
        bus.filldata = 32'hDDCCBBAA;
        edge1();
        rd(8'h24);
        check("rd24_hit", 32'(bus.hit), 32'd1);
        check("rd24_data", 32'(bus.readdata), 32'hAA);
        rd(8'h25);
        check("rd25_data", 32'(bus.readdata), 32'hBB);
        rd(8'h27);
        check("rd27_hit", 32'(bus.hit), 32'd1);
        check("rd27_data", 32'(bus.readdata), 32'hDD);
        check("fill_dirty", 32'(bus.dirty), 32'd0);

        idle();
        bus.address   = 8'h26;
        bus.write     = 1'b1;
        bus.writedata = 8'h5A;
        #1;
        check("wr_hit", 32'(bus.hit), 32'd1);
        edge1();
        check("wr_evict", bus.evict_block, 32'hDD5ABBAA);
        check("wr_dirty", 32'(bus.dirty), 32'd1);
        rd(8'h26);
        check("rd26_data", 32'(bus.readdata), 32'h5A);
        edge1();

        rd(8'hA5);
        check("vic_miss", 32'(bus.miss), 32'd1);
        check("vic_hit", 32'(bus.hit), 32'd0);
        check("vic_dirty", 32'(bus.dirty), 32'd1);
        check("vic_wb", 32'(bus.wb_address), 32'h09);
        check("vic_refill", 32'(bus.refill_address), 32'h29);
        check("vic_evict", bus.evict_block, 32'hDD5ABBAA);

        idle();
        bus.address   = 8'h26;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.writedata = 8'h11;
        #1;
        check("rw_hit", 32'(bus.hit), 32'd0);
        check("rw_miss", 32'(bus.miss), 32'd0);
        edge1();
        edge1();
        check("rw_line", bus.evict_block, 32'hDD5ABBAA);

        idle();
        bus.address   = 8'hA6;
        bus.write     = 1'b1;
        bus.writedata = 8'h77;
        #1;
        check("wmiss_miss", 32'(bus.miss), 32'd1);
        edge1();
        check("wmiss_line", bus.evict_block, 32'hDD5ABBAA);

        idle();
        bus.address   = 8'h24;
        bus.write     = 1'b1;
        bus.writedata = 8'hEE;
        bus.fill      = 1'b1;
        bus.filldata  = 32'h44332211;
        edge1();
        idle();
        #1;
        check("prio_line", bus.evict_block, 32'h44332211);
        check("prio_dirty", 32'(bus.dirty), 32'd0);

        idle();
        bus.address  = 8'hFF;
        bus.fill     = 1'b1;
        bus.filldata = 32'h12345678;
        edge1();
        rd(8'hFF);
        check("l7_hit", 32'(bus.hit), 32'd1);
        check("l7_data", 32'(bus.readdata), 32'h12);
        check("l7_wb", 32'(bus.wb_address), 32'h3F);
        rd(8'h25);
        check("l1_keep", 32'(bus.readdata), 32'h22);
        check("l1_hit", 32'(bus.hit), 32'd1);

        edge1();
        rd(8'h25);
        RESET_CACHE = 1'b0;
        #1;
        check("async_hit", 32'(bus.hit), 32'd0);
        check("async_rdata", 32'(bus.readdata), 32'h0);
        check("async_evict", bus.evict_block, 32'h0);
        edge1();
        RESET_CACHE = 1'b1;
        rd(8'h25);
        check("post_miss", 32'(bus.miss), 32'd1);
        rd(8'hFF);
        check("post_l7", 32'(bus.miss), 32'd1);

        idle();
        bus.address  = 8'h25;
        bus.fill     = 1'b1;
        bus.filldata = 32'hCAFEF00D;
        RESET_CACHE  = 1'b0;
        edge1();
        idle();
        RESET_CACHE = 1'b1;
        rd(8'h25);
        check("rstfill_miss", 32'(bus.miss), 32'd1);
        check("rstfill_line", bus.evict_block, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
